// File: rtl/spi_boot_pkg.sv
// rtl/spi_boot_pkg.sv - shared types and constants for the SPI-flash to SRAM boot loader
// Contents: boot FSM state enum, flash READ opcode, erased-flash word pattern.
package spi_boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_LO,
        ST_RD_HI,
        ST_WRITE,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } boot_state_t;

    localparam logic [7:0]  SPI_READ_CMD = 8'h03;
    localparam logic [15:0] BLANK_WORD   = 16'hFFFF;

endpackage

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - SPI mode-0 byte shifter with SCK divider and start/done handshake
// Ports:
//   clk, resetn      system clock, synchronous active-low reset
//   start, tx_byte   accepted when not busy; tx_byte shifted out MSB first on mosi
//   miso             sampled on each SCK rising edge
//   busy             high while a byte is on the wire
//   done             one-clock pulse after the eighth SCK falling edge; rx_byte valid then
//   sck, mosi        SPI clock (idles low) and master data out
module spi_byte_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       mosi
);

    localparam int DW = $clog2(CLK_DIV + 1);

    logic [DW-1:0] div_cnt;
    logic [2:0]    fall_cnt;
    logic [7:0]    sr_out;
    logic [7:0]    sr_in;
    logic          sck_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt  <= '0;
            fall_cnt <= '0;
            sr_out   <= '0;
            sr_in    <= '0;
            sck_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                // Loading sr_out puts the MSB on mosi while SCK is still low.
                if (start) begin
                    busy_q   <= 1'b1;
                    sr_out   <= tx_byte;
                    div_cnt  <= '0;
                    fall_cnt <= '0;
                end
            end else if (div_cnt == DW'(CLK_DIV - 1)) begin
                div_cnt <= '0;
                if (!sck_q) begin
                    sck_q <= 1'b1;
                    sr_in <= {sr_in[6:0], miso};
                end else begin
                    sck_q    <= 1'b0;
                    sr_out   <= {sr_out[6:0], 1'b0};
                    fall_cnt <= fall_cnt + 3'd1;
                    if (fall_cnt == 3'd7) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_byte = sr_in;
    assign sck     = sck_q;
    assign mosi    = sr_out[7];

endmodule

// File: rtl/spi_sram_bootloader.sv
// rtl/spi_sram_bootloader.sv - copies a fixed-size image from SPI NOR flash into async SRAM after reset
// Ports:
//   master_clk_i, master_rst_i   system clock, synchronous active-low reset
//   MISO, MOSI, SS, SCK_SPI      flash SPI pins (mode 0, SS active low)
//   sram_address_o, sram_datain_o  SRAM word address and write data
//   sram_cs_o, sram_oe_o, sram_we_o, sram_lb_ub_o  SRAM strobes, all active low
//   sram_adv_o, sram_wait_o      tied low (asynchronous SRAM mode)
//   error                        sticky: first word read back as erased flash
module spi_sram_bootloader
    import spi_boot_pkg::*;
#(
    parameter int          CLK_DIV    = 4,
    parameter logic [23:0] FLASH_ADDR = 24'h0,
    parameter int          NUM_WORDS  = 1024,
    parameter logic [21:0] SRAM_BASE  = 22'h0,
    parameter int          WE_CYCLES  = 4
) (
    input  logic        master_clk_i,
    input  logic        master_rst_i,
    input  logic        MISO,
    output logic        MOSI,
    output logic        SS,
    output logic        SCK_SPI,
    output logic [21:0] sram_address_o,
    output logic [15:0] sram_datain_o,
    output logic        sram_cs_o,
    output logic        sram_oe_o,
    output logic        sram_we_o,
    output logic [1:0]  sram_lb_ub_o,
    output logic        sram_adv_o,
    output logic        sram_wait_o,
    output logic        error
);

    localparam int WCW = $clog2(NUM_WORDS) + 1;
    localparam int TW  = $clog2(WE_CYCLES + 2) + 1;

    boot_state_t    state;
    boot_state_t    state_nx;
    logic [1:0]     byte_idx;
    logic [WCW-1:0] word_cnt;
    logic [TW-1:0]  timer;
    logic [21:0]    addr;
    logic [15:0]    data;

    logic           sh_start;
    logic [7:0]     sh_tx;
    logic           sh_busy;
    logic           sh_done;
    logic [7:0]     sh_rx;

    logic           shifting;
    logic           blank;
    logic           wr_active;

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (master_clk_i),
        .resetn  (master_rst_i),
        .start   (sh_start),
        .tx_byte (sh_tx),
        .miso    (MISO),
        .busy    (sh_busy),
        .done    (sh_done),
        .rx_byte (sh_rx),
        .sck     (SCK_SPI),
        .mosi    (MOSI)
    );

    assign shifting = (state == ST_CMD) || (state == ST_ADDR) ||
                      (state == ST_RD_LO) || (state == ST_RD_HI);
    // Only the very first word is checked; later all-ones words are ordinary data.
    assign blank    = (word_cnt == '0) && (data == BLANK_WORD);
    assign wr_active = (state == ST_WRITE) && !blank;

    always_ff @(posedge master_clk_i) begin
        if (!master_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sh_tx    = 8'h00;
        case (state)
            ST_IDLE:  state_nx = ST_CMD;
            ST_CMD: begin
                sh_tx = SPI_READ_CMD;
                if (sh_done) state_nx = ST_ADDR;
            end
            ST_ADDR: begin
                case (byte_idx)
                    2'd0:    sh_tx = FLASH_ADDR[23:16];
                    2'd1:    sh_tx = FLASH_ADDR[15:8];
                    default: sh_tx = FLASH_ADDR[7:0];
                endcase
                if (sh_done && byte_idx == 2'd2) state_nx = ST_RD_LO;
            end
            ST_RD_LO: if (sh_done) state_nx = ST_RD_HI;
            ST_RD_HI: if (sh_done) state_nx = ST_WRITE;
            ST_WRITE: begin
                if (blank) state_nx = ST_ERR;
                else if (timer == TW'(WE_CYCLES + 1)) state_nx = ST_NEXT;
            end
            ST_NEXT:  state_nx = (word_cnt == WCW'(NUM_WORDS - 1)) ? ST_DONE : ST_RD_LO;
            default:  state_nx = state;
        endcase
        // A new byte is launched the clock after the previous one reports done,
        // which keeps SS low across the whole streaming read.
        sh_start = shifting && !sh_busy && !sh_done;
    end

    always_ff @(posedge master_clk_i) begin
        if (!master_rst_i) begin
            byte_idx <= '0;
            word_cnt <= '0;
            timer    <= '0;
            addr     <= SRAM_BASE;
            data     <= '0;
        end else begin
            if (state == ST_ADDR && sh_done) byte_idx <= byte_idx + 2'd1;
            if (state == ST_RD_LO && sh_done) data[7:0] <= sh_rx;
            if (state == ST_RD_HI && sh_done) begin
                data[15:8] <= sh_rx;
                timer      <= '0;
            end
            if (state == ST_WRITE) timer <= timer + TW'(1);
            if (state == ST_NEXT) begin
                addr     <= addr + 22'd1;
                word_cnt <= word_cnt + WCW'(1);
            end
        end
    end

    // Write cycle: timer 0 is address/data setup, 1..WE_CYCLES has we low,
    // WE_CYCLES+1 is the hold clock with cs still asserted.
    assign SS             = !(shifting || state == ST_WRITE || state == ST_NEXT);
    assign sram_address_o = addr;
    assign sram_datain_o  = data;
    assign sram_cs_o      = !wr_active;
    assign sram_lb_ub_o   = wr_active ? 2'b00 : 2'b11;
    assign sram_we_o      = !(wr_active && timer != '0 && timer <= TW'(WE_CYCLES));
    assign sram_oe_o      = 1'b1;
    assign sram_adv_o     = 1'b0;
    assign sram_wait_o    = 1'b0;
    assign error          = (state == ST_ERR);

endmodule

// File: tb/tb_spi_sram_bootloader.sv
// tb/tb_spi_sram_bootloader.sv - self-checking bench for spi_sram_bootloader
module tb_spi_sram_bootloader;

    logic        clk;
    logic [1:0]  rstn;
    logic [1:0]  miso, mosi, ss, sck, cs, oe, we, adv, wt, err;
    logic [1:0]  lb [2];
    logic [21:0] addr [2];
    logic [15:0] dat [2];

    int n_chk;
    int n_fail;

    // Instance 0: main image, two words. Instance 1: single word at top of SRAM, fastest timing.
    spi_sram_bootloader #(
        .CLK_DIV(2), .FLASH_ADDR(24'h0), .NUM_WORDS(2), .SRAM_BASE(22'h0), .WE_CYCLES(3)
    ) dut_a (
        .master_clk_i(clk), .master_rst_i(rstn[0]), .MISO(miso[0]), .MOSI(mosi[0]),
        .SS(ss[0]), .SCK_SPI(sck[0]), .sram_address_o(addr[0]), .sram_datain_o(dat[0]),
        .sram_cs_o(cs[0]), .sram_oe_o(oe[0]), .sram_we_o(we[0]), .sram_lb_ub_o(lb[0]),
        .sram_adv_o(adv[0]), .sram_wait_o(wt[0]), .error(err[0])
    );

    spi_sram_bootloader #(
        .CLK_DIV(1), .FLASH_ADDR(24'h0), .NUM_WORDS(1), .SRAM_BASE(22'h3FFFFF), .WE_CYCLES(1)
    ) dut_b (
        .master_clk_i(clk), .master_rst_i(rstn[1]), .MISO(miso[1]), .MOSI(mosi[1]),
        .SS(ss[1]), .SCK_SPI(sck[1]), .sram_address_o(addr[1]), .sram_datain_o(dat[1]),
        .sram_cs_o(cs[1]), .sram_oe_o(oe[1]), .sram_we_o(we[1]), .sram_lb_ub_o(lb[1]),
        .sram_adv_o(adv[1]), .sram_wait_o(wt[1]), .error(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash model: counts SCK rises while selected, captures the first 32 MOSI
    // bits, then streams mem[] bytes MSB first.
    int          cnt [2];
    logic [31:0] cap [2];
    logic [1:0]  sck_q;
    logic [7:0]  mem [2][4];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            sck_q[k] <= sck[k];
            if (ss[k]) begin
                cnt[k] <= 0;
                cap[k] <= '0;
            end else if (sck[k] && !sck_q[k]) begin
                cnt[k] <= cnt[k] + 1;
                if (cnt[k] < 32) cap[k] <= {cap[k][30:0], mosi[k]};
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            miso[k] = 1'b0;
            if (cnt[k] >= 32)
                miso[k] = mem[k][((cnt[k] - 32) >> 3) & 3][7 - ((cnt[k] - 32) & 7)];
        end
    end

    // SRAM monitor: records each we pulse with its length and a protocol-violation flag.
    logic [1:0]  in_we, bad, prev_cs;
    logic [1:0]  prev_lb [2];
    int          we_len [2];
    logic [21:0] lat_a [2];
    logic [15:0] lat_d [2];
    int          nrec [2];
    logic [21:0] rec_addr [2][4];
    logic [15:0] rec_data [2][4];
    int          rec_len [2][4];
    logic        rec_bad [2][4];

    initial begin
        nrec[0] = 0;
        nrec[1] = 0;
        in_we   = '0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!we[k]) begin
                if (!in_we[k]) begin
                    in_we[k]  <= 1'b1;
                    lat_a[k]  <= addr[k];
                    lat_d[k]  <= dat[k];
                    we_len[k] <= 1;
                    bad[k]    <= !(prev_cs[k] == 1'b0 && prev_lb[k] == 2'b00);
                end else begin
                    we_len[k] <= we_len[k] + 1;
                    if (addr[k] != lat_a[k] || dat[k] != lat_d[k]) bad[k] <= 1'b1;
                end
                if (cs[k] || lb[k] != 2'b00 || !oe[k]) bad[k] <= 1'b1;
            end else if (in_we[k]) begin
                in_we[k] <= 1'b0;
                rec_addr[k][nrec[k] & 3] <= lat_a[k];
                rec_data[k][nrec[k] & 3] <= lat_d[k];
                rec_len[k][nrec[k] & 3]  <= we_len[k];
                rec_bad[k][nrec[k] & 3]  <= bad[k] || cs[k] || lb[k] != 2'b00 ||
                                            addr[k] != lat_a[k] || dat[k] != lat_d[k];
                nrec[k] <= nrec[k] + 1;
            end
            prev_cs[k] <= cs[k];
            prev_lb[k] <= lb[k];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input int k, input logic [21:0] base, input string tag);
        chk({tag, "_ss"},    32'(ss[k]),   32'h1);
        chk({tag, "_sck"},   32'(sck[k]),  32'h0);
        chk({tag, "_mosi"},  32'(mosi[k]), 32'h0);
        chk({tag, "_cs"},    32'(cs[k]),   32'h1);
        chk({tag, "_we"},    32'(we[k]),   32'h1);
        chk({tag, "_oe"},    32'(oe[k]),   32'h1);
        chk({tag, "_lbub"},  32'(lb[k]),   32'h3);
        chk({tag, "_adv"},   32'(adv[k]),  32'h0);
        chk({tag, "_wait"},  32'(wt[k]),   32'h0);
        chk({tag, "_addr"},  32'(addr[k]), 32'(base));
        chk({tag, "_data"},  32'(dat[k]),  32'h0);
        chk({tag, "_error"}, 32'(err[k]),  32'h0);
    endtask

    typedef struct {
        string       name;
        int          inst;
        int          idx;
        logic [21:0] waddr;
        logic [15:0] wdata;
        int          wlen;
    } wr_vec_t;

    wr_vec_t vec [3];
    int      c;
    int      base_rec;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        vec[0] = '{"a_w0", 0, 0, 22'h000000, 16'h1234, 3};
        vec[1] = '{"a_w1", 0, 1, 22'h000001, 16'h5678, 3};
        vec[2] = '{"b_w0", 1, 0, 22'h3FFFFF, 16'h1234, 1};
        mem[0][0] = 8'h34; mem[0][1] = 8'h12; mem[0][2] = 8'h78; mem[0][3] = 8'h56;
        mem[1][0] = 8'h34; mem[1][1] = 8'h12; mem[1][2] = 8'h00; mem[1][3] = 8'h00;

        rstn = 2'b00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_reset(0, 22'h0, "rst_a");
        chk_reset(1, 22'h3FFFFF, "rst_b");
        rstn = 2'b11;

        // Command and address header.
        c = 0;
        while (cnt[0] < 32 && c < 2000) begin @(negedge clk); c++; end
        chk("hdr_timeout", 32'(c < 2000), 32'h1);
        chk("hdr_mosi", cap[0], 32'h03000000);
        chk("hdr_ss_low", 32'(ss[0]), 32'h0);

        c = 0;
        while (!(nrec[0] >= 2 && ss[0] && nrec[1] >= 1 && ss[1]) && c < 4000) begin
            @(negedge clk); c++;
        end
        chk("done_timeout", 32'(c < 4000), 32'h1);
        repeat (20) @(negedge clk);
        chk("a_nrec", 32'(nrec[0]), 32'd2);
        chk("b_nrec", 32'(nrec[1]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk({vec[i].name, "_addr"}, 32'(rec_addr[vec[i].inst][vec[i].idx]), 32'(vec[i].waddr));
            chk({vec[i].name, "_data"}, 32'(rec_data[vec[i].inst][vec[i].idx]), 32'(vec[i].wdata));
            chk({vec[i].name, "_welen"}, 32'(rec_len[vec[i].inst][vec[i].idx]), 32'(vec[i].wlen));
            chk({vec[i].name, "_proto"}, 32'(rec_bad[vec[i].inst][vec[i].idx]), 32'h0);
        end
        chk("a_done_addr", 32'(addr[0]), 32'h2);
        chk("a_done_ss", 32'(ss[0]), 32'h1);
        chk("a_done_sck", 32'(sck[0]), 32'h0);
        chk("a_done_cs", 32'(cs[0]), 32'h1);
        chk("a_done_we", 32'(we[0]), 32'h1);
        chk("a_done_err", 32'(err[0]), 32'h0);
        chk("b_done_addr_wrap", 32'(addr[1]), 32'h0);
        chk("b_done_cs", 32'(cs[1]), 32'h1);

        // Reset in the middle of the second read byte of word 0.
        rstn[0] = 1'b0;
        repeat (3) @(negedge clk);
        rstn[0] = 1'b1;
        c = 0;
        while (cnt[0] < 43 && c < 2000) begin @(negedge clk); c++; end
        chk("rdhi_timeout", 32'(c < 2000), 32'h1);
        rstn[0] = 1'b0;
        @(posedge clk);
        #1;
        chk_reset(0, 22'h0, "midrst");
        repeat (2) @(negedge clk);
        rstn[0] = 1'b1;
        c = 0;
        while (cnt[0] < 8 && c < 2000) begin @(negedge clk); c++; end
        chk("restart_timeout", 32'(c < 2000), 32'h1);
        chk("restart_cmd", 32'(cap[0][7:0]), 32'h03);

        // Blank flash: first word all ones.
        rstn[0] = 1'b0;
        mem[0][0] = 8'hFF; mem[0][1] = 8'hFF; mem[0][2] = 8'h00; mem[0][3] = 8'h00;
        repeat (3) @(negedge clk);
        base_rec = nrec[0];
        rstn[0] = 1'b1;
        c = 0;
        while (!err[0] && c < 2000) begin @(negedge clk); c++; end
        chk("err_timeout", 32'(c < 2000), 32'h1);
        chk("err_ss", 32'(ss[0]), 32'h1);
        repeat (200) @(negedge clk);
        chk("err_sticky", 32'(err[0]), 32'h1);
        chk("err_no_write", 32'(nrec[0] - base_rec), 32'h0);
        chk("err_cs", 32'(cs[0]), 32'h1);
        chk("err_ss_held", 32'(ss[0]), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
